// File: rtl/time_package.sv
// Shared time representation and run-control state encoding for the emulator timing path.
package time_package;

    localparam int TIME_WIDTH = 64;
    typedef logic [TIME_WIDTH-1:0] TIME_FORMAT;

    // Sentinel that no clock generator ever holds; driving it freezes all generators.
    localparam TIME_FORMAT TIME_MAX = '1;

    typedef enum logic [1:0] {
        TM_IDLE,
        TM_RUN,
        TM_PAUSE,
        TM_DONE
    } tm_state_t;

endpackage

// File: rtl/time_manager_if.sv
// Host-side bundle of the time manager: per-clock times, run control and status.
// Inputs are level signals sampled every clock with no handshake; a step is any cycle where time_next != TIME_MAX.
interface time_manager_if #(
    parameter int N_CLOCKS   = 4,
    parameter int STEP_WIDTH = 32,
    parameter int IDX_WIDTH  = (N_CLOCKS > 1) ? $clog2(N_CLOCKS) : 1
);
    import time_package::*;

    TIME_FORMAT              time_in [N_CLOCKS];
    logic [N_CLOCKS-1:0]     clk_en_mask;
    TIME_FORMAT              time_limit;
    logic                    start;
    logic                    stop;
    TIME_FORMAT              time_next;
    logic [IDX_WIDTH-1:0]    min_idx;
    logic                    running;
    logic                    done;
    TIME_FORMAT              emu_time;
    logic [STEP_WIDTH-1:0]   step_count;
    logic                    err_backstep;
    logic                    err_no_clk;
    tm_state_t               state;

    modport master (
        output time_in, clk_en_mask, time_limit, start, stop,
        input  time_next, min_idx, running, done, emu_time, step_count,
               err_backstep, err_no_clk, state
    );

    modport slave (
        input  time_in, clk_en_mask, time_limit, start, stop,
        output time_next, min_idx, running, done, emu_time, step_count,
               err_backstep, err_no_clk, state
    );

endinterface

// File: rtl/time_min_tree.sv
// Combinational masked minimum over N times, binary tree, ties go to the lowest index.
module time_min_tree
    import time_package::*;
#(
    parameter int N         = 4,
    parameter int IDX_WIDTH = (N > 1) ? $clog2(N) : 1
) (
    input  TIME_FORMAT           vals [N],
    input  logic [N-1:0]         mask,
    output TIME_FORMAT           min_val,
    output logic [IDX_WIDTH-1:0] min_idx,
    output logic                 any_valid
);

    localparam int LEVELS = (N > 1) ? $clog2(N) : 0;
    localparam int P      = 1 << LEVELS;
    localparam int NODES  = 2 * P - 1;

    TIME_FORMAT           leaf_val [P];
    logic                 leaf_ok  [P];
    TIME_FORMAT           node_val [NODES];
    logic [IDX_WIDTH-1:0] node_idx [NODES];
    logic                 node_ok  [NODES];
    logic                 take_left;

    for (genvar i = 0; i < P; i++) begin : g_leaf
        if (i < N) begin : g_real
            assign leaf_val[i] = vals[i];
            assign leaf_ok[i]  = mask[i];
        end else begin : g_pad
            assign leaf_val[i] = TIME_MAX;
            assign leaf_ok[i]  = 1'b0;
        end
    end

    // Heap layout: node n has children 2n+1 (lower indices) and 2n+2, so preferring the left child on a tie gives the lowest index.
    always_comb begin
        node_val  = '{default: TIME_MAX};
        node_idx  = '{default: '0};
        node_ok   = '{default: 1'b0};
        take_left = 1'b0;
        for (int i = 0; i < P; i++) begin
            node_val[P-1+i] = leaf_val[i];
            node_idx[P-1+i] = IDX_WIDTH'(i);
            node_ok[P-1+i]  = leaf_ok[i];
        end
        for (int n = P - 2; n >= 0; n--) begin
            take_left = node_ok[2*n+1] &&
                        (!node_ok[2*n+2] || (node_val[2*n+1] <= node_val[2*n+2]));
            node_val[n] = take_left ? node_val[2*n+1] : node_val[2*n+2];
            node_idx[n] = take_left ? node_idx[2*n+1] : node_idx[2*n+2];
            node_ok[n]  = node_ok[2*n+1] || node_ok[2*n+2];
        end
        any_valid = node_ok[0];
        min_val   = node_ok[0] ? node_val[0] : TIME_MAX;
        min_idx   = node_ok[0] ? node_idx[0] : '0;
    end

endmodule

// File: rtl/time_manager.sv
// Global next-event time selection with run control, emulated-time register, step counter and error flags.
module time_manager
    import time_package::*;
#(
    parameter int N_CLOCKS   = 4,
    parameter int STEP_WIDTH = 32,
    parameter int IDX_WIDTH  = (N_CLOCKS > 1) ? $clog2(N_CLOCKS) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    time_manager_if.slave  bus
);

    TIME_FORMAT            times [N_CLOCKS];
    TIME_FORMAT            min_val;
    logic                  any_valid;
    logic                  step;

    tm_state_t             state_q;
    logic                  running_q;
    logic                  done_q;
    TIME_FORMAT            emu_time_q;
    logic [STEP_WIDTH-1:0] step_count_q;
    logic                  err_backstep_q;
    logic                  err_no_clk_q;

    assign times = bus.time_in;

    time_min_tree #(
        .N         (N_CLOCKS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_min_tree (
        .vals      (times),
        .mask      (bus.clk_en_mask),
        .min_val   (min_val),
        .min_idx   (bus.min_idx),
        .any_valid (any_valid)
    );

    // Outside a valid RUN step the sentinel holds every generator still.
    assign step          = (state_q == TM_RUN) && any_valid && (min_val < bus.time_limit);
    assign bus.time_next = step ? min_val : TIME_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= TM_IDLE;
            running_q      <= 1'b0;
            done_q         <= 1'b0;
            emu_time_q     <= '0;
            step_count_q   <= '0;
            err_backstep_q <= 1'b0;
            err_no_clk_q   <= 1'b0;
        end else begin
            case (state_q)
                TM_IDLE, TM_PAUSE: begin
                    if (bus.start) begin
                        state_q   <= TM_RUN;
                        running_q <= 1'b1;
                    end
                end
                TM_RUN: begin
                    if (!any_valid || (min_val >= bus.time_limit)) begin
                        state_q   <= TM_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        if (!any_valid) err_no_clk_q <= 1'b1;
                    end else begin
                        emu_time_q   <= min_val;
                        step_count_q <= step_count_q + STEP_WIDTH'(1);
                        if (min_val < emu_time_q) err_backstep_q <= 1'b1;
                        if (bus.stop) begin
                            state_q   <= TM_PAUSE;
                            running_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= TM_DONE;
                end
            endcase
        end
    end

    assign bus.running      = running_q;
    assign bus.done         = done_q;
    assign bus.emu_time     = emu_time_q;
    assign bus.step_count   = step_count_q;
    assign bus.err_backstep = err_backstep_q;
    assign bus.err_no_clk   = err_no_clk_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_time_manager.sv
// Directed bench for time_manager: expected step times go into a queue, a negedge monitor pops them.
module tb_time_manager;
    import time_package::*;

    localparam int NC = 4;
    localparam int SW = 32;
    localparam int IW = 2;

    logic clk;
    logic rst_n;

    time_manager_if #(.N_CLOCKS(NC), .STEP_WIDTH(SW), .IDX_WIDTH(IW)) bus ();

    time_manager #(.N_CLOCKS(NC), .STEP_WIDTH(SW), .IDX_WIDTH(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Monitor: every step the DUT presents must match the oldest expected step time.
    always @(negedge clk) begin
        if (bus.time_next !== TIME_MAX) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_step: got %0d required no step", bus.time_next);
            end else begin
                check("step_time", bus.time_next, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic set_times(input logic [63:0] t0, input logic [63:0] t1,
                             input logic [63:0] t2, input logic [63:0] t3);
        bus.time_in[0] = t0;
        bus.time_in[1] = t1;
        bus.time_in[2] = t2;
        bus.time_in[3] = t3;
    endtask

    logic [63:0] g0, g1, m;
    int          n_steps;
    bit          fin;

    initial begin
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.clk_en_mask = '0;
        bus.time_limit  = '0;
        set_times(0, 0, 0, 0);

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_running", bus.running, 0);
        check("rst_done", bus.done, 0);
        check("rst_emu_time", bus.emu_time, 0);
        check("rst_step_count", bus.step_count, 0);
        check("rst_err_backstep", bus.err_backstep, 0);
        check("rst_err_no_clk", bus.err_no_clk, 0);
        check("rst_time_next", bus.time_next, TIME_MAX);
        check("rst_state", bus.state, TM_IDLE);
        cyc();
        rst_n = 1'b1;

        // ---- group 1: idle hold, first step, stop/resume, no-clock ----
        set_times(40, 10, 10, 30);
        bus.clk_en_mask = 4'b1111;
        bus.time_limit  = 1000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_time_next", bus.time_next, TIME_MAX);
        end
        check("idle_step_count", bus.step_count, 0);

        cyc(); bus.start = 1'b1;
        cyc(); bus.start = 1'b0; bus.stop = 1'b1; exp_q.push_back(10);
        @(negedge clk);
        check("first_running", bus.running, 1);
        check("first_min_idx", bus.min_idx, 1);
        cyc(); bus.stop = 1'b0;
        @(negedge clk);
        check("first_emu_time", bus.emu_time, 10);
        check("first_step_count", bus.step_count, 1);
        check("paused_running", bus.running, 0);
        check("paused_time_next", bus.time_next, TIME_MAX);

        cyc(); bus.stop = 1'b1;
        cyc(); bus.stop = 1'b0;
        @(negedge clk);
        check("pause_stop_ignored", bus.state, TM_PAUSE);
        check("pause_step_frozen", bus.step_count, 1);

        cyc(); bus.start = 1'b1; bus.stop = 1'b1;
        cyc(); bus.start = 1'b0; bus.stop = 1'b1; exp_q.push_back(10);
        @(negedge clk);
        check("resume_running", bus.running, 1);
        cyc(); bus.stop = 1'b0;
        @(negedge clk);
        check("resume_step_count", bus.step_count, 2);
        check("equal_time_no_backstep", bus.err_backstep, 0);

        cyc(); bus.start = 1'b1;
        cyc(); bus.start = 1'b0; bus.clk_en_mask = 4'b0000;
        cyc(); bus.clk_en_mask = 4'b1111;
        @(negedge clk);
        check("noclk_done", bus.done, 1);
        check("noclk_flag", bus.err_no_clk, 1);
        check("noclk_running", bus.running, 0);
        check("noclk_step_count", bus.step_count, 2);
        cyc(); bus.start = 1'b1;
        cyc(); bus.start = 1'b0;
        @(negedge clk);
        check("done_ignores_start", bus.state, TM_DONE);
        check("done_time_next", bus.time_next, TIME_MAX);
        check("done_step_count", bus.step_count, 2);
        check("g1_queue_empty", exp_q.size(), 0);

        // ---- group 2: two generators (7, 11) run to limit 100 ----
        do_reset();
        bus.clk_en_mask = 4'b0011;
        bus.time_limit  = 100;
        g0 = 7; g1 = 11; n_steps = 0; fin = 1'b0;
        set_times(g0, g1, 3, 5);
        cyc(); bus.start = 1'b1;
        for (int k = 0; k < 40 && !fin; k++) begin
            cyc();
            bus.start = 1'b0;
            set_times(g0, g1, 3, 5);
            m = (g0 <= g1) ? g0 : g1;
            if (m < 100) begin
                exp_q.push_back(m);
                n_steps++;
                if (g0 == m) g0 = g0 + 7;
                if (g1 == m) g1 = g1 + 11;
            end else begin
                fin = 1'b1;
            end
        end
        cyc();
        @(negedge clk);
        check("limit_done", bus.done, 1);
        check("limit_time_next", bus.time_next, TIME_MAX);
        check("limit_emu_time", bus.emu_time, 99);
        check("limit_step_count", bus.step_count, n_steps);
        check("limit_err_no_clk", bus.err_no_clk, 0);
        check("g2_queue_empty", exp_q.size(), 0);

        // ---- group 3: backstep, then asynchronous reset mid-RUN ----
        do_reset();
        bus.clk_en_mask = 4'b0001;
        bus.time_limit  = 1000;
        set_times(50, 0, 0, 0);
        cyc(); bus.start = 1'b1;
        cyc(); bus.start = 1'b0; exp_q.push_back(50);
        cyc(); bus.time_in[0] = 20; bus.stop = 1'b1; exp_q.push_back(20);
        cyc(); bus.stop = 1'b0;
        @(negedge clk);
        check("backstep_flag", bus.err_backstep, 1);
        check("backstep_emu_time", bus.emu_time, 20);
        check("backstep_step_count", bus.step_count, 2);
        repeat (3) cyc();
        check("backstep_sticky", bus.err_backstep, 1);

        cyc(); bus.start = 1'b1; bus.time_in[0] = 30;
        cyc(); bus.start = 1'b0;
        check("pre_reset_time_next", bus.time_next, 30);
        check("pre_reset_running", bus.running, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_time_next", bus.time_next, TIME_MAX);
        check("arst_running", bus.running, 0);
        check("arst_done", bus.done, 0);
        check("arst_emu_time", bus.emu_time, 0);
        check("arst_step_count", bus.step_count, 0);
        check("arst_err_backstep", bus.err_backstep, 0);
        check("arst_err_no_clk", bus.err_no_clk, 0);
        check("arst_state", bus.state, TM_IDLE);
        @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
